// File: rtl/tick_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tick_serial_tx
// Description : Tick-paced LSB-first serial frame transmitter
//               (idle-high start / data / [parity] / stop framing).
//               Optional even parity: define TICK_SERIAL_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_serial_tx #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] c_LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_START  = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
`ifdef TICK_SERIAL_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd5;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tx;
    logic [DATA_W-1:0] w_shift_next;
`ifdef TICK_SERIAL_TX_PARITY_EN
    logic              r_parity;
`endif

    assign w_shift_next = r_shift >> 1;

    assign tx_ready = (r_state == c_ST_IDLE);
    assign busy     = (r_state != c_ST_IDLE);
    assign tx       = r_tx;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_tx     <= 1'b1;
`ifdef TICK_SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tx <= 1'b1;
                    // tick is deliberately ignored here: the frame always
                    // starts on a strobe strictly after the accept edge
                    if (tx_valid) begin
                        r_shift  <= tx_data;
                        r_cnt    <= '0;
                        r_state  <= c_ST_WAIT;
`ifdef TICK_SERIAL_TX_PARITY_EN
                        r_parity <= ^tx_data;
`endif
                    end
                end
                c_ST_WAIT: begin
                    if (tick) begin
                        r_tx    <= 1'b0;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (tick) begin
                        r_tx    <= r_shift[0];
                        r_cnt   <= '0;
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (tick) begin
                        r_shift <= w_shift_next;
                        if (r_cnt < c_LAST_BIT) begin
                            r_tx  <= w_shift_next[0];
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end else begin
`ifdef TICK_SERIAL_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= c_ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= c_ST_STOP;
`endif
                        end
                    end
                end
`ifdef TICK_SERIAL_TX_PARITY_EN
                c_ST_PARITY: begin
                    if (tick) begin
                        r_tx    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= c_ST_STOP;
                    end
                end
`endif
                c_ST_STOP: begin
                    r_tx <= 1'b1;
                    if (tick) begin
                        if (r_cnt == c_LAST_STOP) begin
                            r_cnt   <= '0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
